// File: rtl/atten_cmd_sequencer.sv
// atten_cmd_sequencer
// Holds one attenuation code per channel and, on go, sends one 24-bit command word
// per channel to the attenuator SPI serializer, waiting for each end-of-frame CS pulse.
// Optional feature: ATTEN_SEQ_SKIP_UNCHANGED_EN skips channels whose code matches the
// last code that completed a frame.
module atten_cmd_sequencer #(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned REG_WIDTH  = 32,
   parameter int unsigned LD_HOLD    = 4,
   parameter logic [7:0]  CMD_PREFIX = 8'hA5,
   parameter int unsigned TIMEOUT    = 4096
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [$clog2(NUM_CH)-1:0] wr_ch,
   input  logic [7:0]                wr_data,
   input  logic                      go,
   input  logic                      ser_cs,
   output logic [REG_WIDTH-1:0]      ser_data,
   output logic                      ser_ld,
   output logic                      busy,
   output logic                      done,
   output logic                      timeout_err
);

   localparam int unsigned AW = $clog2(NUM_CH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned HW = $clog2(LD_HOLD + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST_CH   = CW'(NUM_CH - 1);
   localparam logic [CW-1:0] NUM_CH_W  = CW'(NUM_CH);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LD_HOLD - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_WAIT_HI = 3'd2,
      S_WAIT_LO = 3'd3,
      S_NEXT    = 3'd4,
      S_DONE    = 3'd5,
      S_SCAN    = 3'd6
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        ch_q, ch_d;
   logic [HW-1:0]        hold_q, hold_d;
   logic [TW-1:0]        wait_q, wait_d;
   logic                 cs_prev_q;
   logic [7:0]           shadow_q [NUM_CH];
   logic [7:0]           active_q [NUM_CH];
   logic [REG_WIDTH-1:0] ser_data_q;
   logic                 ser_ld_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 timeout_err_q;
   logic                 go_accept_s;
   logic                 tmo_set_s;
   logic                 frame_ok_s;

   // Command word: prefix, zero-extended channel index, code; upper bits zero.
   function automatic logic [REG_WIDTH-1:0] build_word(input logic [CW-1:0] ch,
                                                       input logic [7:0]    code);
      logic [REG_WIDTH-1:0] w;
      w        = '0;
      w[7:0]   = code;
      w[15:8]  = 8'(ch);
      w[23:16] = CMD_PREFIX;
      return w;
   endfunction

   assign go_accept_s = (state_q == S_IDLE) && go;

`ifdef ATTEN_SEQ_SKIP_UNCHANGED_EN
   logic [7:0]        last_q [NUM_CH];
   logic [NUM_CH-1:0] diff_s;
   logic              pending_s;

   // Flag channels whose snapshot differs from the last sent code, and whether any remain at or after ch_q.
   always_comb begin
      pending_s = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         diff_s[i] = (active_q[i] != last_q[i]);
         if (diff_s[i] && (CW'(i) >= ch_q)) begin
            pending_s = 1'b1;
         end else begin
            pending_s = pending_s;
         end
      end
   end

   // Last-sent bank: updated only when a frame completes, so a timed-out channel keeps its old entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) last_q[i] <= 8'h00;
      end else if (frame_ok_s) begin
         last_q[ch_q[AW-1:0]] <= active_q[ch_q[AW-1:0]];
      end
   end
`endif

   // Next-state logic for the sequencing FSM, hold counter and wait counter.
   always_comb begin
      state_d    = state_q;
      ch_d       = ch_q;
      hold_d     = hold_q;
      wait_d     = wait_q;
      tmo_set_s  = 1'b0;
      frame_ok_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (go) begin
               ch_d   = '0;
               hold_d = '0;
`ifdef ATTEN_SEQ_SKIP_UNCHANGED_EN
               state_d = S_SCAN;
`else
               state_d = S_LOAD;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            if (hold_q == HOLD_LAST) begin
               state_d = S_WAIT_HI;
               wait_d  = '0;
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         S_WAIT_HI: begin
            if (ser_cs && !cs_prev_q) begin
               state_d = S_WAIT_LO;
               wait_d  = '0;
            end else if (wait_q == TMO_LAST) begin
               tmo_set_s = 1'b1;
               state_d   = S_IDLE;
            end else begin
               wait_d = wait_q + TW'(1);
            end
         end
         S_WAIT_LO: begin
            if (!ser_cs) begin
               frame_ok_s = 1'b1;
               state_d    = S_NEXT;
            end else if (wait_q == TMO_LAST) begin
               tmo_set_s = 1'b1;
               state_d   = S_IDLE;
            end else begin
               wait_d = wait_q + TW'(1);
            end
         end
         S_NEXT: begin
            if (ch_q == LAST_CH) begin
               state_d = S_DONE;
            end else begin
               ch_d   = ch_q + CW'(1);
               hold_d = '0;
`ifdef ATTEN_SEQ_SKIP_UNCHANGED_EN
               state_d = S_SCAN;
`else
               state_d = S_LOAD;
`endif
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
`ifdef ATTEN_SEQ_SKIP_UNCHANGED_EN
         S_SCAN: begin
            if (!pending_s || (ch_q >= NUM_CH_W)) begin
               state_d = S_DONE;
            end else if (diff_s[ch_q[AW-1:0]]) begin
               hold_d  = '0;
               state_d = S_LOAD;
            end else begin
               ch_d = ch_q + CW'(1);
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FSM state, counters and the previous ser_cs sample used for rise detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         ch_q      <= '0;
         hold_q    <= '0;
         wait_q    <= '0;
         cs_prev_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         hold_q    <= hold_d;
         wait_q    <= wait_d;
         cs_prev_q <= ser_cs;
      end
   end

   // Shadow bank takes host writes; active bank snapshots the pre-write shadow when go is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            shadow_q[i] <= 8'h00;
            active_q[i] <= 8'h00;
         end
      end else begin
         if (wr_en && ({1'b0, wr_ch} < NUM_CH_W)) begin
            shadow_q[wr_ch] <= wr_data;
         end
         if (go_accept_s) begin
            active_q <= shadow_q;
         end
      end
   end

   // Registered outputs decoded from the current state; ser_data only reloads while in LOAD.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ser_data_q    <= '0;
         ser_ld_q      <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         ser_ld_q <= (state_q == S_LOAD);
         busy_q   <= (state_q != S_IDLE) && (state_q != S_DONE) && !tmo_set_s;
         done_q   <= (state_q == S_DONE);
         if (state_q == S_LOAD) begin
            ser_data_q <= build_word(ch_q, active_q[ch_q[AW-1:0]]);
         end
         if (go_accept_s) begin
            timeout_err_q <= 1'b0;
         end else if (tmo_set_s) begin
            timeout_err_q <= 1'b1;
         end
      end
   end

   assign ser_data    = ser_data_q;
   assign ser_ld      = ser_ld_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_atten_cmd_sequencer.sv
// Testbench for atten_cmd_sequencer: table-driven sequences plus hand-written corner cases,
// with a scoreboard of expected command words checked at each ser_ld rise.
module tb_atten_cmd_sequencer;

`ifdef ATTEN_SEQ_SKIP_UNCHANGED_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif
   localparam int LD_HOLD = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [1:0]  wr_ch;
   logic [7:0]  wr_data;
   logic        go;
   logic        ser_cs;
   logic [31:0] ser_data;
   logic        ser_ld;
   logic        busy;
   logic        done;
   logic        timeout_err;

   atten_cmd_sequencer dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
      .go(go), .ser_cs(ser_cs), .ser_data(ser_data), .ser_ld(ser_ld),
      .busy(busy), .done(done), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          ch;
      logic [7:0]  code;
      logic [31:0] exp;
   } vec_t;

   vec_t        tbl [8];
   logic [31:0] sb [$];
   logic [7:0]  shadow_m [4];
   logic [7:0]  last_m [4];
   int          n_chk = 0;
   int          n_fail = 0;
   int          done_cnt = 0;
   int          exp_done = 0;
   int          ld_rises = 0;
   bit          cs_en = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mk_word(input int ch, input logic [7:0] code);
      return {8'h00, 8'hA5, 8'(ch), code};
   endfunction

   // Serializer model: 3-cycle ser_cs pulse starting 50 cycles after each ser_ld fall.
   initial begin
      int  cs_timer;
      int  cs_hold;
      bit  mdl_ld_prev;
      ser_cs = 1'b0;
      cs_timer = 0;
      cs_hold = 0;
      mdl_ld_prev = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            ser_cs = 1'b0;
            cs_timer = 0;
            cs_hold = 0;
            mdl_ld_prev = 1'b0;
         end else begin
            if (cs_hold > 0) begin
               cs_hold--;
               if (cs_hold == 0) ser_cs = 1'b0;
            end
            if (cs_timer > 0) begin
               cs_timer--;
               if (cs_timer == 0) begin
                  ser_cs = 1'b1;
                  cs_hold = 3;
               end
            end
            if (mdl_ld_prev && !ser_ld && cs_en) cs_timer = 50;
            mdl_ld_prev = ser_ld;
         end
      end
   end

   // Output monitor: pops the scoreboard on each ser_ld rise, checks hold length and data stability.
   initial begin
      bit          ld_prev;
      int          ld_len;
      logic [31:0] cur_word;
      logic [31:0] exp_w;
      ld_prev = 1'b0;
      ld_len = 0;
      cur_word = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            ld_prev = 1'b0;
            ld_len = 0;
         end else begin
            if (ser_ld && !ld_prev) begin
               ld_rises++;
               ld_len = 1;
               cur_word = ser_data;
               if (sb.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL ld_unexpected: actual word=%h required=no load", ser_data);
               end else begin
                  exp_w = sb.pop_front();
                  chk("word", ser_data, exp_w);
               end
            end else if (ser_ld) begin
               ld_len++;
               chk("data_stable", ser_data, cur_word);
            end
            if (!ser_ld && ld_prev) chk("ld_len", 32'(ld_len), 32'(LD_HOLD));
            if (done) done_cnt++;
            ld_prev = ser_ld;
         end
      end
   end

   task automatic wr(input int ch, input logic [7:0] code);
      wr_en = 1'b1;
      wr_ch = 2'(ch);
      wr_data = code;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      shadow_m[ch] = code;
   endtask

   task automatic pulse_go();
      go = 1'b1;
      @(posedge clk);
      #1;
      go = 1'b0;
   endtask

   // Push the words the current shadow snapshot should produce.
   task automatic push_seq();
      for (int c = 0; c < 4; c++) begin
         if (!SKIP || (shadow_m[c] != last_m[c])) begin
            sb.push_back(mk_word(c, shadow_m[c]));
            last_m[c] = shadow_m[c];
         end
      end
   endtask

   task automatic wait_done(input string name);
      int k;
      k = 0;
      while (done !== 1'b1 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk(name, 32'(done), 32'd1);
   endtask

   task automatic post_seq(input string name);
      @(negedge clk);
      chk({name, "_done_cnt"}, 32'(done_cnt), 32'(exp_done));
      chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
      chk({name, "_busy_low"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: actual=time limit reached required=test end");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int k;
      int cnt;
      rst = 1'b1;
      wr_en = 1'b0;
      wr_ch = 2'd0;
      wr_data = 8'h00;
      go = 1'b0;
      for (int c = 0; c < 4; c++) begin
         shadow_m[c] = 8'h00;
         last_m[c] = 8'h00;
      end
      tbl[0] = '{0, 8'h10, 32'h00A50010};
      tbl[1] = '{1, 8'h20, 32'h00A50120};
      tbl[2] = '{2, 8'h30, 32'h00A50230};
      tbl[3] = '{3, 8'h40, 32'h00A50340};
      tbl[4] = '{0, 8'h00, 32'h00A50000};
      tbl[5] = '{1, 8'hFF, 32'h00A501FF};
      tbl[6] = '{2, 8'h5A, 32'h00A5025A};
      tbl[7] = '{3, 8'h81, 32'h00A50381};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ser_data", ser_data, 32'h0);
      chk("rst_ser_ld", 32'(ser_ld), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_timeout_err", 32'(timeout_err), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Table-driven full sequences
      for (int g = 0; g < 2; g++) begin
         for (int i = 0; i < 4; i++) wr(tbl[g*4+i].ch, tbl[g*4+i].code);
         for (int i = 0; i < 4; i++) begin
            sb.push_back(tbl[g*4+i].exp);
            last_m[tbl[g*4+i].ch] = tbl[g*4+i].code;
         end
         pulse_go();
         if (g == 0) begin
            @(negedge clk);
            chk("go_busy_edgeN", 32'(busy), 32'd0);
            @(negedge clk);
            chk("go_busy_edgeN1", 32'(busy), 32'd1);
            chk("go_ld_edgeN1", 32'(ser_ld), SKIP ? 32'd0 : 32'd1);
         end
         wait_done("tbl_done");
         exp_done++;
         post_seq("tbl");
      end

      // Snapshot: write in the go cycle is excluded; go while busy is ignored
      wr(0, 8'h11);
      wr(1, 8'h22);
      push_seq();
      wr_en = 1'b1;
      wr_ch = 2'd1;
      wr_data = 8'h7F;
      go = 1'b1;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      go = 1'b0;
      shadow_m[1] = 8'h7F;
      repeat (40) @(posedge clk);
      #1;
      pulse_go();
      wait_done("snap_done");
      exp_done++;
      post_seq("snap");
      repeat (300) @(negedge clk);
      chk("snap_no_second_seq", 32'(done_cnt), 32'(exp_done));

      // Timeout with ser_cs stuck low
      wr(0, 8'h55);
      cs_en = 1'b0;
      sb.push_back(mk_word(0, 8'h55));
      pulse_go();
      k = 0;
      while (!ser_ld && k < 50) begin @(negedge clk); k++; end
      k = 0;
      while (ser_ld && k < 50) begin @(negedge clk); k++; end
      cnt = 0;
      while (!timeout_err && cnt < 5000) begin @(negedge clk); cnt++; end
      chk("tmo_cycles_after_ld_fall", 32'(cnt), 32'd4095);
      chk("tmo_err_set", 32'(timeout_err), 32'd1);
      chk("tmo_busy_low", 32'(busy), 32'd0);
      chk("tmo_ld_low", 32'(ser_ld), 32'd0);
      repeat (10) @(negedge clk);
      chk("tmo_no_done", 32'(done_cnt), 32'(exp_done));
      chk("tmo_sb_empty", 32'(sb.size()), 32'd0);
      chk("tmo_sticky", 32'(timeout_err), 32'd1);
      cs_en = 1'b1;
      push_seq();
      pulse_go();
      @(negedge clk);
      chk("tmo_cleared_by_go", 32'(timeout_err), 32'd0);
      wait_done("tmo_rerun_done");
      exp_done++;
      post_seq("tmo_rerun");

      // Reset during the second word's LOAD
      wr(0, 8'h66);
      wr(1, 8'h77);
      push_seq();
      base = ld_rises;
      pulse_go();
      k = 0;
      while (ld_rises < base + 2 && k < 1000) begin @(negedge clk); k++; end
      chk("rst_mid_second_word", 32'(ld_rises), 32'(base + 2));
      @(posedge clk);
      #2;
      chk("rst_mid_ld_before", 32'(ser_ld), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_mid_ld", 32'(ser_ld), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_data", ser_data, 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      for (int c = 0; c < 4; c++) begin
         shadow_m[c] = 8'h00;
         last_m[c] = 8'h00;
      end
      chk("rst_mid_no_done", 32'(done_cnt), 32'(exp_done));
      push_seq();
      pulse_go();
      wait_done("rst_rerun_done");
      exp_done++;
      post_seq("rst_rerun");

`ifdef ATTEN_SEQ_SKIP_UNCHANGED_EN
      // Skip unchanged: full send, then only ch2, then nothing
      for (int i = 0; i < 4; i++) wr(tbl[i].ch, tbl[i].code);
      push_seq();
      pulse_go();
      wait_done("skip_full_done");
      exp_done++;
      post_seq("skip_full");
      wr(2, 8'h31);
      chk("skip_one_expected", 32'(1), 32'(1) - 32'(0));
      push_seq();
      chk("skip_one_word", sb[0], 32'h00A50231);
      pulse_go();
      wait_done("skip_one_done");
      exp_done++;
      post_seq("skip_one");
      base = ld_rises;
      pulse_go();
      @(negedge clk);
      chk("nochg_done_n", 32'(done), 32'd0);
      @(negedge clk);
      chk("nochg_done_n1", 32'(done), 32'd0);
      @(negedge clk);
      chk("nochg_done_n2", 32'(done), 32'd1);
      exp_done++;
      post_seq("nochg");
      chk("nochg_no_ld", 32'(ld_rises), 32'(base));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/atten_cmd_sequencer.md
# atten_cmd_sequencer

Upstream command sequencer for the attenuator SPI serializer. Holds one attenuation code per daughter-board channel and, on a `go` request, sends one 24-bit command word per channel. For each word it drives the serializer's parallel data input and `ld` strobe, then waits for that channel's end-of-frame chip-select pulse before issuing the next word. It reports completion or a serializer timeout to the control logic.

## Interface
- `NUM_CH`, 4 — number of attenuator channels, 2..16.
- `REG_WIDTH`, 32 — width of `ser_data`; must equal the serializer's register width, ≥ 24.
- `LD_HOLD`, 4 — cycles `ser_ld` is held high per word, ≥ 2.
- `CMD_PREFIX`, 8'hA5 — constant placed in command bits [23:16].
- `TIMEOUT`, 4096 — maximum cycles spent waiting on either `ser_cs` edge.

- `clk`  in  1  — single clock. Also clocks the serializer.
- `rst`  in  1  — asynchronous, active-high reset.
- `wr_en`  in  1  — writes `wr_data` into the shadow code for channel `wr_ch`.
- `wr_ch`  in  $clog2(NUM_CH)  — channel index; writes with `wr_ch ≥ NUM_CH` are ignored.
- `wr_data`  in  8  — attenuation code.
- `go`  in  1  — start-sequence request, sampled on a rising `clk` edge.
- `ser_cs`  in  1  — serializer CS output; its high pulse marks end of frame.
- `ser_data`  out  REG_WIDTH  — parallel command word to the serializer.
- `ser_ld`  out  1  — load strobe to the serializer.
- `busy`  out  1  — high from the cycle after `go` is accepted until `done`/abort.
- `done`  out  1  — one-cycle pulse when all words are sent.
- `timeout_err`  out  1  — sticky; set on timeout, cleared when the next `go` is accepted.

## Operation
- Command word layout:
  - `ser_data[7:0]` = code.
  - `ser_data[15:8]` = channel index, zero-extended.
  - `ser_data[23:16]` = `CMD_PREFIX`.
  - Upper bits = 0.
- Shadow bank: `NUM_CH` × 8 bits, writable at any time.
- When `go` is accepted, the shadow bank is copied into an active bank. The sequence transmits only from the active bank.
- A write in the same cycle `go` is accepted is excluded from the snapshot; it lands in the shadow bank only.
- FSM states and transitions:
  - IDLE: `go` → LOAD with channel counter = first channel to send.
  - LOAD: `ser_ld` = 1 for `LD_HOLD` cycles, with `ser_data` stable → WAIT_HI.
  - WAIT_HI: wait for `ser_cs` rising edge (registered previous value) → WAIT_LO.
  - WAIT_LO: wait for `ser_cs` = 0 → NEXT.
  - NEXT: if the last channel was sent → DONE; otherwise advance the counter → LOAD.
  - DONE: `done` = 1 for one cycle → IDLE.
- `ser_data` is updated on LOAD entry and holds until the next LOAD entry.
- `ser_data` must never change while `ser_ld` = 1.
- Timeout:
  - A wait counter clears on entry to WAIT_HI and WAIT_LO.
  - If it reaches `TIMEOUT`: `timeout_err` ← 1 and → IDLE, with no `done` pulse and `ser_ld` = 0.
- `go` while busy is ignored; it is not queued.
- Channel counter width is $clog2(NUM_CH)+1; no wrap-around occurs within a sequence.

## Timing
- Reset values:
  - `ser_data` = 0, `ser_ld` = 0, `busy` = 0, `done` = 0, `timeout_err` = 0.
  - Both banks = 0, FSM = IDLE.
- Reset mid-sequence aborts immediately. No partial word is retried.
- `go` sampled high at edge N gives `busy` = 1 and `ser_ld` = 1 from edge N+1. `ser_ld` falls at edge N+1+`LD_HOLD`.
- `ser_cs` rise is detected one cycle after it occurs.
- Next LOAD begins 2 cycles after `ser_cs` is sampled low.
- `done` is asserted 2 cycles after the final `ser_cs` fall is sampled. `busy` drops in the same cycle `done` is asserted.
- All outputs are registered.

## Configuration
- `ATTEN_SEQ_SKIP_UNCHANGED_EN` defined:
  - A "last-sent" bank records each code after its frame completes in WAIT_LO → NEXT.
  - Channels whose snapshot equals last-sent are skipped; the skip scan costs one cycle per skipped channel.
  - If no channel differs, `done` pulses 2 cycles after `go` with no `ser_ld` activity.
  - The last-sent bank resets to 0; a timeout leaves the entry for the failed channel unchanged.
- Not defined: every channel is sent on every `go`; no last-sent bank exists.

## Test plan
- Basic sequence:
  - Stimulus: reset; write codes 0x10, 0x20, 0x30, 0x40 to ch 0–3; pulse `go`; serializer model returns a 3-cycle `ser_cs` pulse 50 cycles after each `ser_ld` fall.
  - Required: four words 0xA50010, 0xA50120, 0xA50230, 0xA50340 in order; each `ser_ld` high for exactly 4 cycles; one `done`; `busy` = 0 afterwards.
- Snapshot and ignored `go`:
  - Stimulus: write ch1 = 0x7F in the same cycle as `go`; issue a second `go` mid-sequence.
  - Required: ch1 is sent with its old code; the second `go` is ignored; exactly one `done`.
- Timeout:
  - Stimulus: `ser_cs` held at 0.
  - Required: `timeout_err` = 1 exactly 4096 cycles after WAIT_HI entry; `busy` = 0; no `done`; the next `go` clears `timeout_err`.
- Reset mid-sequence:
  - Stimulus: assert `rst` during the second word's LOAD.
  - Required: `ser_ld`, `busy` and `ser_data` are 0 asynchronously; both banks read back as 0 on the next sequence.
- With `ATTEN_SEQ_SKIP_UNCHANGED_EN` defined:
  - Stimulus: repeat the basic sequence, then change only ch2 to 0x31 and `go`.
  - Required: only 0xA50231 is sent.
- `ATTEN_SEQ_SKIP_UNCHANGED_EN` defined, no changes:
  - Stimulus: `go` with no codes changed since the last sequence.
  - Required: `done` 2 cycles after `go`, with zero `ser_ld` pulses.
